mem_access_unit: RTL and testbench

Initiator-side load/store unit that sits between the single-cycle datapath's execute stage and the word-organised data memory. It accepts byte, halfword and word load/store requests over a valid/ready handshake. It translates byte addresses into word indices, performs read-modify-write for sub-word stores, sign- or zero-extends sub-word loads, and returns one response per request. Misaligned and out-of-range accesses are rejected without touching memory.

---
 rtl/mem_access_pkg.sv | 32 +++
 rtl/lsu_align.sv | 52 +++++
 rtl/mem_access_unit.sv | 144 ++++++++++++++
 tb/tb_mem_access_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared types and constants for the load/store unit.
package mem_access_pkg;

  localparam int unsigned DEPTH_WORDS_DEF = 64;
  localparam int unsigned DATA_W          = 32;
  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned LANE_W          = 2;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  // Request fields kept after accept; only the byte lane of the address is needed later.
  typedef struct packed {
    logic              we;
    size_e             size;
    logic              uns;
    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_align
  import mem_access_pkg::*;
(
  input  logic [DATA_W-1:0] i_word,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [LANE_W-1:0] i_lane,
  input  size_e             i_size,
  input  logic              i_unsigned,
  output logic [DATA_W-1:0] o_rdata_c,
  output logic [DATA_W-1:0] o_merged_c
);

  // Select the addressed lane and sign- or zero-extend it.
  function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] w,
                                                 input logic [LANE_W-1:0] lane,
                                                 input size_e sz,
                                                 input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = lane[1] ? w[31:16] : w[15:0];
    case (sz)
      SZ_BYTE: extract = {{24{b[7] & ~uns}}, b};
      SZ_HALF: extract = {{16{h[15] & ~uns}}, h};
      default: extract = w;
    endcase
  endfunction

  // Replace only the addressed lane with the low bits of the store data.
  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] w,
                                               input logic [DATA_W-1:0] wd,
                                               input logic [LANE_W-1:0] lane,
                                               input size_e sz);
    merge = w;
    case (sz)
      SZ_BYTE: merge[{lane, 3'b000} +: 8] = wd[7:0];
      SZ_HALF: begin
        if (lane[1]) merge[31:16] = wd[15:0];
        else         merge[15:0]  = wd[15:0];
      end
      default: merge = wd;
    endcase
  endfunction

  // Both results are always computed; the FSM picks the one it needs.
  always_comb begin
    o_rdata_c  = extract(i_word, i_lane, i_size, i_unsigned);
    o_merged_c = merge(i_word, i_wdata, i_lane, i_size);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: request handshake, error screening, read-modify-write and response.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            r_state;
  state_e            w_next;
  req_t              r_req;
  size_e             w_size;
  logic              w_accept;
  logic              w_err;
  logic              w_word_store;
  logic [DATA_W-1:0] w_rdata_c;
  logic [DATA_W-1:0] w_merged_c;

  logic              r_req_ready;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_we;

  assign w_size       = size_e'(req_size);
  assign w_accept     = req_valid && r_req_ready;
  assign w_word_store = req_we && (w_size == SZ_WORD);

  // Screen the incoming request for illegal size, misalignment and range.
  always_comb begin
    w_err = 1'b0;
    case (w_size)
      SZ_HALF: w_err = req_addr[0];
      SZ_WORD: w_err = |req_addr[1:0];
      SZ_ILL:  w_err = 1'b1;
      default: w_err = 1'b0;
    endcase
    if ({2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS)) w_err = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_err)             w_next = ST_RESP;
          else if (w_word_store) w_next = ST_WR;
          else                   w_next = ST_RD;
        end
      end
      ST_RD:   w_next = r_req.we ? ST_WR : ST_RESP;
      ST_WR:   w_next = ST_RESP;
      ST_RESP: if (resp_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Capture the request fields needed after the accept edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req <= '0;
    end else if (w_accept) begin
      r_req.we    <= req_we;
      r_req.size  <= w_size;
      r_req.uns   <= req_unsigned;
      r_req.lane  <= req_addr[1:0];
      r_req.wdata <= req_wdata;
    end
  end

  lsu_align u_align (
    .i_word     (mem_rdata),
    .i_wdata    (r_req.wdata),
    .i_lane     (r_req.lane),
    .i_size     (r_req.size),
    .i_unsigned (r_req.uns),
    .o_rdata_c  (w_rdata_c),
    .o_merged_c (w_merged_c)
  );

  // Registered outputs; strobes follow the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_we     <= 1'b0;
    end else begin
      r_req_ready  <= (w_next == ST_IDLE);
      r_resp_valid <= (w_next == ST_RESP);
      r_mem_we     <= (w_next == ST_WR);
      if (w_accept) begin
        r_resp_err   <= w_err;
        r_resp_rdata <= '0;
        if (!w_err) begin
          r_mem_addr <= 32'(req_addr[31:2]);
          if (w_word_store) r_mem_wdata <= req_wdata;
        end
      end
      if (r_state == ST_RD) begin
        if (r_req.we) r_mem_wdata  <= w_merged_c;
        else          r_resp_rdata <= w_rdata_c;
      end
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_we     = r_mem_we;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a word memory and an arithmetic reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic        env_init = 1'b1;
  int          wr_count = 0;
  logic [31:0] wr_addr = '0;
  logic [31:0] wr_data = '0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_rdata    (mem_rdata)
  );

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
  endfunction

  // Attached memory: combinational read, write committed on the falling edge.
  assign mem_rdata = (mem_addr < 32'd64) ? mem[mem_addr[5:0]] : 32'h0;

  always @(negedge clk) begin
    if (env_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= seed_word(i);
    end else if (mem_we) begin
      mem[mem_addr[5:0]] <= mem_wdata;
      wr_count <= wr_count + 1;
      wr_addr  <= mem_addr;
      wr_data  <= mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One request end to end: the model predicts error, data, memory effect and latency.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input int stall,
                        output logic [31:0] rd, output logic er);
    int cyc, wr0, idx, lane, exp_lat;
    logic [31:0] w, nw, exp_rd, addr0, mask;
    logic exp_err;
    idx     = int'(addr / 4);
    lane    = int'(addr % 4);
    exp_err = (sz == 2'd3) || (sz == 2'd1 && (addr % 2) != 0) ||
              (sz == 2'd2 && (addr % 4) != 0) || (addr / 4 >= 64);
    w      = exp_err ? 32'h0 : ref_mem[idx];
    exp_rd = 32'h0;
    nw     = w;
    mask   = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
    if (!exp_err) begin
      if (!we) begin
        exp_rd = (w >> (8 * lane)) & mask;
        if (!uns && sz == 2'd0 && exp_rd >= 32'd128)   exp_rd = exp_rd + 32'hFFFFFF00;
        if (!uns && sz == 2'd1 && exp_rd >= 32'd32768) exp_rd = exp_rd + 32'hFFFF0000;
      end else begin
        nw = (w & ~(mask << (8 * lane))) | ((wd & mask) << (8 * lane));
      end
    end
    exp_lat = exp_err ? 1 : (we && sz != 2'd2) ? 3 : 2;

    cyc = 0;
    while (req_ready !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    addr0 = mem_addr;
    wr0   = wr_count;
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    resp_ready = (stall == 0);
    cyc = 1;
    while (resp_valid !== 1'b1 && cyc < 10) begin @(posedge clk); #1; cyc++; end
    chk("latency", 32'(cyc), 32'(exp_lat));
    chk("resp_valid", 32'(resp_valid), 32'd1);
    chk("resp_rdata", resp_rdata, exp_rd);
    chk("resp_err", 32'(resp_err), 32'(exp_err));
    chk("req_ready_busy", 32'(req_ready), 32'd0);
    if (!exp_err && we) begin
      chk("wr_addr", wr_addr, 32'(idx));
      chk("wr_data", wr_data, nw);
    end
    rd = resp_rdata;
    er = resp_err;
    for (int s = 0; s < stall; s++) begin
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h0;
      @(posedge clk); #1;
      chk("stall_valid", 32'(resp_valid), 32'd1);
      chk("stall_rdata", resp_rdata, exp_rd);
      chk("stall_err", 32'(resp_err), 32'(exp_err));
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("resp_drop", 32'(resp_valid), 32'd0);
    chk("ready_back", 32'(req_ready), 32'd1);
    chk("write_count", 32'(wr_count - wr0), (exp_err || !we) ? 32'd0 : 32'd1);
    if (exp_err) chk("err_addr_hold", mem_addr, addr0);
    else begin
      ref_mem[idx] = nw;
      chk("mem_word", mem[idx], nw);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rd, old;
    logic        er;
    int          wr0;
    logic [31:0] a;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = seed_word(i);

    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); #1 env_init = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Word store then load.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0, rd, er);
    chk("sw_addr_const", wr_addr, 32'd4);
    chk("sw_data_const", wr_data, 32'hDEADBEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0, rd, er);
    chk("lw_const", rd, 32'hDEADBEEF);

    // Byte merge and extension.
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 0, rd, er);
    do_req(1'b1, 2'd0, 1'b0, 32'h12, 32'h000000AA, 0, rd, er);
    chk("sb_merge_const", wr_data, 32'h11AA3344);
    do_req(1'b0, 2'd0, 1'b0, 32'h12, 32'h0, 0, rd, er);
    chk("lb_const", rd, 32'hFFFFFFAA);
    do_req(1'b0, 2'd0, 1'b1, 32'h12, 32'h0, 0, rd, er);
    chk("lbu_const", rd, 32'h000000AA);
    do_req(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 0, rd, er);
    chk("lh_const", rd, 32'h000011AA);

    // Error cases.
    do_req(1'b0, 2'd1, 1'b0, 32'h11, 32'h0, 0, rd, er);
    chk("err_lh_const", 32'(er), 32'd1);
    do_req(1'b1, 2'd2, 1'b0, 32'h102, 32'h12345678, 0, rd, er);
    chk("err_sw_const", 32'(er), 32'd1);
    do_req(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 0, rd, er);
    chk("err_range_const", 32'(er), 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 0, rd, er);
    chk("err_size_const", 32'(er), 32'd1);

    // Backpressure with a competing request held during the stall.
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5, rd, er);

    // Reset while the word store is in its write cycle.
    wr0 = wr_count;
    old = mem[8];
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wr_strobe", 32'(mem_we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rwr_mem_we", 32'(mem_we), 32'd0);
    chk("rwr_req_ready", 32'(req_ready), 32'd0);
    chk("rwr_resp_valid", 32'(resp_valid), 32'd0);
    chk("rwr_resp_rdata", resp_rdata, 32'd0);
    chk("rwr_resp_err", 32'(resp_err), 32'd0);
    chk("rwr_mem_addr", mem_addr, 32'd0);
    chk("rwr_mem_wdata", mem_wdata, 32'd0);
    @(negedge clk); #1;
    chk("rwr_no_write", 32'(wr_count - wr0), 32'd0);
    chk("rwr_mem_keep", mem[8], old);
    @(negedge clk); rst_n = 1'b1;

    // Randomized traffic against the reference model.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'($urandom_range(0, 67)) * 32'd4 + 32'($urandom_range(0, 3));
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, int'($urandom_range(0, 2)), rd, er);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
